// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-register pipelined shift execute stage.
// S1 latches operand/shamt/op/tag from decode. A 5-level log shifter then computes
// SLL/SRL/SRA/ROR from S1, and the result plus tag is latched into S2 for writeback.
// Both stages use a valid/ready handshake, and flush kills everything in flight.
// Optional feature macro: SHIFT_FLAGS_EN adds registered out_zero/out_neg flags.
module shift_exec_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [4:0]       in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg
`endif
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // One level of the log shifter: shift by the fixed amount n (1,2,4,8 or 16).
    // SRA fills with the original operand sign at every level.
    function automatic logic [31:0] shift_level(input logic [31:0] v,
                                                input logic [1:0]  op,
                                                input logic        sign,
                                                input logic [4:0]  n);
        logic [31:0] fill;
        logic [31:0] r;
        fill = sign ? ~(32'hFFFF_FFFF >> n) : 32'h0000_0000;
        case (op)
            OP_SLL:  r = v << n;
            OP_SRL:  r = v >> n;
            OP_SRA:  r = (v >> n) | fill;
            OP_ROR:  r = (v >> n) | (v << (6'd32 - {1'b0, n}));
            default: r = v;
        endcase
        return r;
    endfunction

    // Stage 1 state.
    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_a_q,     s1_a_d;
    logic [4:0]       s1_shamt_q, s1_shamt_d;
    logic [1:0]       s1_op_q,    s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    // Stage 2 state. It drives the outputs directly.
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_data_q,  s2_data_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
`ifdef SHIFT_FLAGS_EN
    logic             s2_zero_q,  s2_zero_d;
    logic             s2_neg_q,   s2_neg_d;
`endif

    logic        accept_s;
    logic        xfer_s;
    logic        pop_s;
    logic [31:0] shift_res_s;
    logic [31:0] lvl_s [0:5];

    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;
    assign xfer_s   = s1_valid_q && (!s2_valid_q || out_ready);
    assign pop_s    = s2_valid_q && out_ready;

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
`ifdef SHIFT_FLAGS_EN
    assign out_zero  = s2_zero_q;
    assign out_neg   = s2_neg_q;
`endif

    // Log shifter on S1: level k applies a shift of 2^k when shamt bit k is set.
    always_comb begin
        lvl_s[0] = s1_a_q;
        for (int k = 0; k < 5; k++) begin
            lvl_s[k+1] = s1_shamt_q[k] ? shift_level(lvl_s[k], s1_op_q, s1_a_q[31], 5'(1 << k))
                                       : lvl_s[k];
        end
        shift_res_s = lvl_s[5];
    end

    // Next-state logic. Flush wins over accept and transfer; data registers may keep stale values.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_shamt_d = s1_shamt_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
`ifdef SHIFT_FLAGS_EN
        s2_zero_d  = s2_zero_q;
        s2_neg_d   = s2_neg_q;
`endif
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (xfer_s) begin
                s2_valid_d = 1'b1;
                s2_data_d  = shift_res_s;
                s2_tag_d   = s1_tag_q;
`ifdef SHIFT_FLAGS_EN
                s2_zero_d  = (shift_res_s == 32'h0000_0000);
                s2_neg_d   = shift_res_s[31];
`endif
            end else if (pop_s) begin
                s2_valid_d = 1'b0;
            end else begin
                s2_valid_d = s2_valid_q;
            end
            if (accept_s) begin
                s1_valid_d = 1'b1;
                s1_a_d     = in_a;
                s1_shamt_d = in_shamt;
                s1_op_d    = in_op;
                s1_tag_d   = in_tag;
            end else if (xfer_s) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end
        end
    end

    // State registers with synchronous active-low reset that clears valids and outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= 32'h0000_0000;
            s1_shamt_q <= 5'd0;
            s1_op_q    <= 2'b00;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= 32'h0000_0000;
            s2_tag_q   <= '0;
`ifdef SHIFT_FLAGS_EN
            s2_zero_q  <= 1'b0;
            s2_neg_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_shamt_q <= s1_shamt_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
`ifdef SHIFT_FLAGS_EN
            s2_zero_q  <= s2_zero_d;
            s2_neg_q   <= s2_neg_d;
`endif
        end
    end

endmodule
